// File: rtl/card_hand_bank.sv
// card_hand_bank: bank of NUM_HANDS baccarat hands, each up to MAX_CARDS cards.
// One card is dealt per cycle through a valid/ready handshake. Each hand keeps
// registered slots, last card, score (sum of values mod 10), count and full flag.
// Per-hand clears take priority over a deal to the same hand.
module card_hand_bank #(
    parameter int NUM_HANDS    = 2,
    parameter int MAX_CARDS    = 3,
    parameter int USE_EXT_CARD = 0,
    localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int CW = $clog2(MAX_CARDS + 1)
) (
    input  logic                            slow_clock,
    input  logic                            reset,
    input  logic                            deal_valid,
    input  logic [HW-1:0]                   deal_hand,
    input  logic [3:0]                      card_in,
    input  logic [NUM_HANDS-1:0]            clear_hand,
    output logic                            deal_ready,
    output logic                            deal_done,
    output logic [NUM_HANDS*MAX_CARDS*4-1:0] cards,
    output logic [NUM_HANDS*4-1:0]          last_card,
    output logic [NUM_HANDS*4-1:0]          score,
    output logic [NUM_HANDS*CW-1:0]         card_count,
    output logic [NUM_HANDS-1:0]            hand_full
);

    logic [3:0]           dealer_q;
    logic                 done_q;
    logic [3:0]           deal_code;
    logic [3:0]           card_value;
    logic                 card_ok;
    logic                 accept;
    logic [NUM_HANDS-1:0] hand_ok;

    // Card source: external port or the free-running internal dealer.
    assign deal_code  = (USE_EXT_CARD != 0) ? card_in : dealer_q;
    // A, 2..9 count at face value; 10 and court cards count zero.
    assign card_value = (deal_code <= 4'd9) ? deal_code : 4'd0;
    // External codes outside 1..13 are never accepted.
    assign card_ok    = (USE_EXT_CARD == 0) || ((card_in >= 4'd1) && (card_in <= 4'd13));
    // An out-of-range deal_hand matches no hand, so hand_ok stays all zero.
    assign deal_ready = (|hand_ok) && card_ok;
    assign accept     = deal_valid && deal_ready;
    assign deal_done  = done_q;

    // Dealer counter cycles 1..13 every clock; done pulses the cycle after an accept.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            dealer_q <= 4'd1;
            done_q   <= 1'b0;
        end else begin
            dealer_q <= (dealer_q == 4'd13) ? 4'd1 : dealer_q + 4'd1;
            done_q   <= accept;
        end
    end

    for (genvar gi = 0; gi < NUM_HANDS; gi++) begin : g_hand
        logic [3:0]    slot_q [MAX_CARDS];
        logic [3:0]    last_q;
        logic [3:0]    score_q;
        logic [CW-1:0] count_q;
        logic          full_q;
        logic          hit;
        logic          load;
        logic [4:0]    sum_d;
        logic [3:0]    score_d;
        logic [CW-1:0] count_d;

        assign hit         = (deal_hand == HW'(gi));
        assign hand_ok[gi] = hit && !full_q && !clear_hand[gi];
        assign load        = accept && hit;
        assign sum_d       = {1'b0, score_q} + {1'b0, card_value};
        assign score_d     = (sum_d >= 5'd10) ? 4'(sum_d - 5'd10) : sum_d[3:0];
        assign count_d     = count_q + CW'(1);

        // Hand state: clear beats deal; a deal fills the slot indexed by the count.
        always_ff @(posedge slow_clock or posedge reset) begin
            if (reset) begin
                for (int s = 0; s < MAX_CARDS; s++) slot_q[s] <= 4'd0;
                last_q  <= 4'd0;
                score_q <= 4'd0;
                count_q <= '0;
                full_q  <= 1'b0;
            end else if (clear_hand[gi]) begin
                for (int s = 0; s < MAX_CARDS; s++) slot_q[s] <= 4'd0;
                last_q  <= 4'd0;
                score_q <= 4'd0;
                count_q <= '0;
                full_q  <= 1'b0;
            end else if (load) begin
                for (int s = 0; s < MAX_CARDS; s++) begin
                    if (count_q == CW'(s)) slot_q[s] <= deal_code;
                end
                last_q  <= deal_code;
                score_q <= score_d;
                count_q <= count_d;
                full_q  <= (count_d == CW'(MAX_CARDS));
            end
        end

        for (genvar si = 0; si < MAX_CARDS; si++) begin : g_slot
            assign cards[(gi*MAX_CARDS+si)*4 +: 4] = slot_q[si];
        end
        assign last_card[gi*4 +: 4]   = last_q;
        assign score[gi*4 +: 4]       = score_q;
        assign card_count[gi*CW +: CW] = count_q;
        assign hand_full[gi]          = full_q;
    end

endmodule
